// File: rtl/vga_bounce_box.sv
// vga_bounce_box: bouncing square image source for a VGA raster.
// Motion and flash state advance once per frame during vertical blanking.
module vga_bounce_box #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          BOX_SIZE     = 32,
  parameter int          STEP_X       = 2,
  parameter int          STEP_Y       = 1,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [11:0] BOX_RGB      = 12'hF80,
  parameter logic [11:0] FLASH_RGB    = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h008
) (
  input  logic        clk,
  input  logic        i_sclr,
  input  logic        i_px_clk,
  input  logic        i_haddr_en,
  input  logic [9:0]  i_hidx,
  input  logic        i_vaddr_en,
  input  logic [8:0]  i_vidx,
  input  logic        i_pause,
  output logic [3:0]  o_vga_red,
  output logic [3:0]  o_vga_green,
  output logic [3:0]  o_vga_blue,
  output logic        o_bounce,
  output logic [15:0] o_frame_cnt
);

  localparam int X_MAX = H_ACTIVE - BOX_SIZE;
  localparam int Y_MAX = V_ACTIVE - BOX_SIZE;
  localparam int FW    = $clog2(FLASH_FRAMES + 1);

  typedef enum logic {
    S_DRAW,
    S_UPDATE
  } state_t;

  state_t         r_state;
  logic [9:0]     r_box_x;
  logic [8:0]     r_box_y;
  logic           r_dir_x;
  logic           r_dir_y;
  logic [FW-1:0]  r_flash_cnt;
  logic           r_vaddr_en_d;
  logic [15:0]    r_frame_cnt;
  logic           r_bounce;
  logic [11:0]    r_rgb;

  state_t         w_state_nxt;
  logic [9:0]     w_box_x_nxt;
  logic [8:0]     w_box_y_nxt;
  logic           w_dir_x_nxt;
  logic           w_dir_y_nxt;
  logic [FW-1:0]  w_flash_nxt;
  logic           w_bounce_nxt;
  logic           w_frame_inc;
  logic           w_hit_x;
  logic           w_hit_y;

  logic           w_frame_end;
  logic           w_active;
  logic           w_inside;
  logic [10:0]    w_x11;
  logic [10:0]    w_y11;
  logic [10:0]    w_h11;
  logic [10:0]    w_v11;
  logic [10:0]    w_x_plus;
  logic [10:0]    w_y_plus;

  assign w_frame_end = r_vaddr_en_d & ~i_vaddr_en;
  assign w_active    = i_haddr_en & i_vaddr_en;

  assign w_x11    = {1'b0, r_box_x};
  assign w_y11    = {2'b0, r_box_y};
  assign w_h11    = {1'b0, i_hidx};
  assign w_v11    = {2'b0, i_vidx};
  assign w_x_plus = w_x11 + 11'(STEP_X);
  assign w_y_plus = w_y11 + 11'(STEP_Y);

  assign w_inside = (w_h11 >= w_x11)
                  & (w_h11 < w_x11 + 11'(BOX_SIZE))
                  & (w_v11 >= w_y11)
                  & (w_v11 < w_y11 + 11'(BOX_SIZE));

  // Next-state logic: frame detection and once-per-frame motion update
  always_comb begin
    w_state_nxt  = r_state;
    w_box_x_nxt  = r_box_x;
    w_box_y_nxt  = r_box_y;
    w_dir_x_nxt  = r_dir_x;
    w_dir_y_nxt  = r_dir_y;
    w_flash_nxt  = r_flash_cnt;
    w_bounce_nxt = 1'b0;
    w_frame_inc  = 1'b0;
    w_hit_x      = 1'b0;
    w_hit_y      = 1'b0;
    unique case (r_state)
      S_DRAW: begin
        if (w_frame_end) begin
          w_state_nxt = S_UPDATE;
          w_frame_inc = 1'b1;
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_DRAW;
        if (r_flash_cnt != '0) begin
          w_flash_nxt = r_flash_cnt - FW'(1);
        end
        if (!i_pause) begin
          if (r_dir_x) begin
            if (w_x_plus >= 11'(X_MAX)) begin
              w_box_x_nxt = 10'(X_MAX);
              w_dir_x_nxt = 1'b0;
              w_hit_x     = 1'b1;
            end else begin
              w_box_x_nxt = w_x_plus[9:0];
            end
          end else begin
            if (w_x11 <= 11'(STEP_X)) begin
              w_box_x_nxt = '0;
              w_dir_x_nxt = 1'b1;
              w_hit_x     = 1'b1;
            end else begin
              w_box_x_nxt = r_box_x - 10'(STEP_X);
            end
          end
          if (r_dir_y) begin
            if (w_y_plus >= 11'(Y_MAX)) begin
              w_box_y_nxt = 9'(Y_MAX);
              w_dir_y_nxt = 1'b0;
              w_hit_y     = 1'b1;
            end else begin
              w_box_y_nxt = w_y_plus[8:0];
            end
          end else begin
            if (w_y11 <= 11'(STEP_Y)) begin
              w_box_y_nxt = '0;
              w_dir_y_nxt = 1'b1;
              w_hit_y     = 1'b1;
            end else begin
              w_box_y_nxt = r_box_y - 9'(STEP_Y);
            end
          end
          if (w_hit_x | w_hit_y) begin
            w_bounce_nxt = 1'b1;
            w_flash_nxt  = FW'(FLASH_FRAMES);
          end
        end
      end
    endcase
  end

  // State, motion and frame-counter registers
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_state      <= S_DRAW;
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_flash_cnt  <= '0;
      r_vaddr_en_d <= 1'b0;
      r_frame_cnt  <= '0;
      r_bounce     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_box_x      <= w_box_x_nxt;
      r_box_y      <= w_box_y_nxt;
      r_dir_x      <= w_dir_x_nxt;
      r_dir_y      <= w_dir_y_nxt;
      r_flash_cnt  <= w_flash_nxt;
      r_vaddr_en_d <= i_vaddr_en;
      r_bounce     <= w_bounce_nxt;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Pixel colour register, advanced on each pixel enable; blanking is black
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_rgb <= '0;
    end else if (i_px_clk) begin
      if (!w_active) begin
        r_rgb <= '0;
      end else if (w_inside) begin
        r_rgb <= (r_flash_cnt != '0) ? FLASH_RGB : BOX_RGB;
      end else begin
        r_rgb <= BG_RGB;
      end
    end
  end

  assign o_vga_red   = r_rgb[11:8];
  assign o_vga_green = r_rgb[7:4];
  assign o_vga_blue  = r_rgb[3:0];
  assign o_bounce    = r_bounce;
  assign o_frame_cnt = r_frame_cnt;

endmodule
